// File: rtl/udp_header_tx_pkg.sv
// Shared types and constants for the UDP header transmitter.
// Package name udp_pkg is kept short so it can be reused by the UDP payload stage.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRC_PORT_TX,
    DST_PORT_TX,
    LEN_TX,
    CSUM_TX
  } udp_tx_state_e;

  localparam logic [7:0]  UDP_PROTO   = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  // MSB-first byte pick from a 16-bit header field.
  function automatic logic [7:0] field_byte(input logic [15:0] word, input logic lsb_sel);
    return lsb_sel ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/udp_header_tx_if.sv
// Start/field/stream bundle between the IP header stage, the UDP header
// transmitter and the payload stage.
interface udp_header_tx_if;
  logic        ip_header_tx_udp_done;
  logic [15:0] udp_s_port;
  logic [15:0] udp_d_port;
  logic [15:0] udp_len;
  logic [31:0] ip_s_addr;
  logic [31:0] ip_d_addr;
  logic [31:0] payload_sum;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        udp_header_tx_done;

  modport master (
    output ip_header_tx_udp_done, udp_s_port, udp_d_port, udp_len,
           ip_s_addr, ip_d_addr, payload_sum,
    input  data_out, data_valid, udp_header_tx_done
  );

  modport slave (
    input  ip_header_tx_udp_done, udp_s_port, udp_d_port, udp_len,
           ip_s_addr, ip_d_addr, payload_sum,
    output data_out, data_valid, udp_header_tx_done
  );
endinterface

// File: rtl/udp_header_tx_csum16_fold.sv
// Combinational 32->16 one's-complement fold with final inversion.
// Two carry passes are enough: the first sum is at most 17 bits wide.
module csum16_fold (
  input  logic [31:0] sum,
  output logic [15:0] csum
);
  logic [16:0] pass1;
  logic [16:0] pass2;

  always_comb begin
    pass1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    pass2 = {1'b0, pass1[15:0]} + {16'h0000, pass1[16]};
    csum  = ~pass2[15:0];
  end
endmodule

// File: rtl/udp_header_tx.sv
// UDP header serialiser: 8 bytes MSB-first after the IP header stage's done pulse.
// Optional checksum generation is enabled with `define UDP_CHECKSUM_EN.
module udp_header_tx
  import udp_pkg::*;
#(
  parameter int HDR_BYTES = int'(UDP_HDR_LEN)
) (
  input  logic aclk,
  input  logic areset,
  udp_header_tx_if.slave bus
);

  udp_tx_state_e state_q, state_d;
  logic          cnt_q, cnt_d;
  logic          start_accept;

  logic [15:0] s_port_q;
  logic [15:0] d_port_q;
  logic [15:0] len_q;
  logic [15:0] csum_word;

  assign start_accept = (state_q == IDLE) && bus.ip_header_tx_udp_done;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers: inputs are only guaranteed stable in the start cycle.
  always_ff @(posedge aclk) begin
    if (start_accept) begin
      s_port_q <= bus.udp_s_port;
      d_port_q <= bus.udp_d_port;
      len_q    <= bus.udp_len + 16'(HDR_BYTES);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 1'b0;
      if (bus.ip_header_tx_udp_done) state_d = SRC_PORT_TX;
    end else begin
      cnt_d = ~cnt_q;
      if (cnt_q) begin
        unique case (state_q)
          SRC_PORT_TX: state_d = DST_PORT_TX;
          DST_PORT_TX: state_d = LEN_TX;
          LEN_TX:      state_d = CSUM_TX;
          default:     state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    logic [15:0] word;
    word                   = 16'h0000;
    bus.data_out           = 8'h00;
    bus.data_valid         = 1'b0;
    bus.udp_header_tx_done = 1'b0;
    unique case (state_q)
      SRC_PORT_TX: word = s_port_q;
      DST_PORT_TX: word = d_port_q;
      LEN_TX:      word = len_q;
      CSUM_TX:     word = csum_word;
      default:     word = 16'h0000;
    endcase
    if (state_q != IDLE) begin
      bus.data_valid         = 1'b1;
      bus.data_out           = field_byte(word, cnt_q);
      bus.udp_header_tx_done = (state_q == CSUM_TX) && cnt_q;
    end
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0] ip_s_q;
  logic [31:0] ip_d_q;
  logic [31:0] payload_q;
  logic [31:0] acc_q;
  logic [15:0] csum_q;
  logic [15:0] term_a;
  logic [31:0] term_b;
  logic        acc_en;
  logic        fold_en;
  logic [15:0] csum_raw;

  always_ff @(posedge aclk) begin
    if (start_accept) begin
      ip_s_q    <= bus.ip_s_addr;
      ip_d_q    <= bus.ip_d_addr;
      payload_q <= bus.payload_sum;
    end
  end

  // Two pseudo-header/header terms per byte cycle, last pair in the first LEN byte.
  always_comb begin
    term_a  = 16'h0000;
    term_b  = 32'h0000_0000;
    acc_en  = 1'b0;
    fold_en = 1'b0;
    unique case (state_q)
      SRC_PORT_TX: begin
        acc_en = 1'b1;
        term_a = cnt_q ? ip_d_q[31:16] : ip_s_q[31:16];
        term_b = {16'h0000, (cnt_q ? ip_d_q[15:0] : ip_s_q[15:0])};
      end
      DST_PORT_TX: begin
        acc_en = 1'b1;
        term_a = cnt_q ? s_port_q : {8'h00, UDP_PROTO};
        term_b = {16'h0000, (cnt_q ? d_port_q : len_q)};
      end
      LEN_TX: begin
        if (cnt_q) begin
          fold_en = 1'b1;
        end else begin
          acc_en = 1'b1;
          term_a = len_q;
          term_b = payload_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset || start_accept) acc_q <= 32'h0000_0000;
    else if (acc_en)            acc_q <= acc_q + {16'h0000, term_a} + term_b;
  end

  csum16_fold u_fold (
    .sum  (acc_q),
    .csum (csum_raw)
  );

  // A zero checksum means "none" on the wire, so it is sent as all-ones.
  always_ff @(posedge aclk) begin
    if (fold_en) csum_q <= (csum_raw == 16'h0000) ? 16'hFFFF : csum_raw;
  end

  assign csum_word = csum_q;
`else
  logic unused_csum_inputs;
  assign unused_csum_inputs = ^{bus.ip_s_addr, bus.ip_d_addr, bus.payload_sum};
  assign csum_word = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_header_tx.sv
// Directed bench for udp_header_tx; checksum expectations follow UDP_CHECKSUM_EN.
module tb_udp_header_tx;
  import udp_pkg::*;

`ifdef UDP_CHECKSUM_EN
  localparam logic [15:0] CS_A = 16'h15DE;
  localparam logic [15:0] CS_B = 16'hFFFF;
  localparam logic [15:0] CS_W = 16'h182C;
  localparam logic [15:0] CS_C = 16'h7A64;
`else
  localparam logic [15:0] CS_A = 16'h0000;
  localparam logic [15:0] CS_B = 16'h0000;
  localparam logic [15:0] CS_W = 16'h0000;
  localparam logic [15:0] CS_C = 16'h0000;
`endif

  logic aclk;
  logic areset;
  int   total;
  int   bad;

  udp_header_tx_if bus ();

  udp_header_tx #(.HDR_BYTES(8)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {15'd0, bus.data_valid}, 16'h0000);
    chk({tag, "_data"}, {8'd0, bus.data_out}, 16'h0000);
    chk({tag, "_done"}, {15'd0, bus.udp_header_tx_done}, 16'h0000);
  endtask

  // Called at a negedge; raises start for one cycle and returns at the negedge of N+1.
  task automatic start_frame(input logic [15:0] sp, input logic [15:0] dp,
                             input logic [15:0] ln, input logic [31:0] pl);
    bus.udp_s_port            = sp;
    bus.udp_d_port            = dp;
    bus.udp_len               = ln;
    bus.payload_sum           = pl;
    bus.ip_header_tx_udp_done = 1'b1;
    @(negedge aclk);
    bus.ip_header_tx_udp_done = 1'b0;
  endtask

  // Checks bytes in N+1..N+8 and the idle cycle N+9; optional busy pulse and restart.
  task automatic expect_frame(input string tag, input logic [63:0] exp,
                              input int busy_k, input bit restart);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), {15'd0, bus.data_valid}, 16'h0001);
      chk($sformatf("%s_byte%0d", tag, k), {8'd0, bus.data_out}, {8'd0, exp[63-8*k -: 8]});
      chk($sformatf("%s_done%0d", tag, k), {15'd0, bus.udp_header_tx_done},
          (k == 7) ? 16'h0001 : 16'h0000);
      if (k == busy_k) begin
        bus.udp_s_port            = 16'hDEAD;
        bus.udp_d_port            = 16'hBEEF;
        bus.udp_len               = 16'h0100;
        bus.ip_header_tx_udp_done = 1'b1;
      end else begin
        bus.ip_header_tx_udp_done = 1'b0;
      end
      @(negedge aclk);
    end
    chk_idle({tag, "_after"});
    if (restart) begin
      bus.udp_s_port            = 16'h0102;
      bus.udp_d_port            = 16'h0304;
      bus.udp_len               = 16'h0010;
      bus.payload_sum           = 32'h0;
      bus.ip_header_tx_udp_done = 1'b1;
      @(negedge aclk);
      bus.ip_header_tx_udp_done = 1'b0;
    end
  endtask

  initial begin
    total                     = 0;
    bad                       = 0;
    areset                    = 1'b1;
    bus.ip_header_tx_udp_done = 1'b0;
    bus.udp_s_port            = 16'h0;
    bus.udp_d_port            = 16'h0;
    bus.udp_len               = 16'h0;
    bus.ip_s_addr             = 32'hC0A8_0001;
    bus.ip_d_addr             = 32'hC0A8_0002;
    bus.payload_sum           = 32'h0;

    repeat (3) @(negedge aclk);
    chk_idle("reset");
    areset = 1'b0;
    @(negedge aclk);
    chk_idle("post_reset");

    start_frame(16'h1234, 16'h5678, 16'h0000, 32'h0);
    expect_frame("basic", {48'h1234_5678_0008, CS_A}, -1, 1'b0);

    start_frame(16'h1234, 16'h5678, 16'h0000, 32'h0000_15DE);
    expect_frame("zerocs", {48'h1234_5678_0008, CS_B}, -1, 1'b0);

    start_frame(16'hAAAA, 16'hBBBB, 16'hFFFC, 32'h0);
    bus.udp_s_port  = 16'h0;
    bus.udp_d_port  = 16'h0;
    bus.udp_len     = 16'h0;
    bus.ip_s_addr   = 32'h0;
    bus.ip_d_addr   = 32'h0;
    bus.payload_sum = 32'h0;
    expect_frame("wrap", {48'hAAAA_BBBB_0004, CS_W}, -1, 1'b0);
    bus.ip_s_addr = 32'hC0A8_0001;
    bus.ip_d_addr = 32'hC0A8_0002;

    // Busy pulse at N+3 (byte index 2), restart at N+9.
    start_frame(16'h1234, 16'h5678, 16'h0000, 32'h0);
    expect_frame("busy", {48'h1234_5678_0008, CS_A}, 2, 1'b1);
    expect_frame("b2b", {48'h0102_0304_0018, CS_C}, -1, 1'b0);

    start_frame(16'h1234, 16'h5678, 16'h0000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_byte%0d", k), {8'd0, bus.data_out},
          {8'd0, 32'h1234_5678 >> (24 - 8*k) & 32'hFF} );
      @(negedge aclk);
      if (k == 2) areset = 1'b1;
    end
    chk_idle("rst_hit");
    areset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge aclk);
      chk($sformatf("rst_quiet_valid%0d", k), {15'd0, bus.data_valid}, 16'h0000);
      chk($sformatf("rst_quiet_done%0d", k), {15'd0, bus.udp_header_tx_done}, 16'h0000);
    end

    start_frame(16'h1234, 16'h5678, 16'h0000, 32'h0);
    expect_frame("recover", {48'h1234_5678_0008, CS_A}, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_header_tx.md
Name: udp_header_tx

Overview:
Serialises the 8-byte UDP header onto the shared TX byte stream. It sits directly downstream of the IPv4 header transmitter and is started by that block's ip_header_tx_udp_done pulse. It emits source port, destination port, UDP length and checksum MSB-first, one byte per clock. It then pulses udp_header_tx_done so the payload stage can begin streaming.

Parameters:
- HDR_BYTES, 8, UDP header length in bytes; fixed, used for the length field and the byte counter.

Ports:
- aclk  in  1  system clock; all logic on its rising edge.
- areset  in  1  synchronous reset, active-high.
- ip_header_tx_udp_done  in  1  single-cycle start pulse from the IP header stage.
- udp_s_port  in  16  UDP source port.
- udp_d_port  in  16  UDP destination port.
- udp_len  in  16  payload length in bytes; the same value the IP stage receives.
- ip_s_addr  in  32  IPv4 source address, used for the pseudo-header.
- ip_d_addr  in  32  IPv4 destination address, used for the pseudo-header.
- payload_sum  in  32  unfolded 32-bit sum of the payload as 16-bit big-endian words; an odd trailing byte is zero-padded.
- data_out  out  8  header byte.
- data_valid  out  1  high while data_out carries a header byte.
- udp_header_tx_done  out  1  single-cycle pulse, coincident with the last header byte.

Behaviour:
- Reset (areset=1 at a clock edge): state=IDLE, byte counter=0, data_out=8'h00, data_valid=0, udp_header_tx_done=0, accumulator=0.
- Reset asserted mid-frame: the block returns to IDLE on that edge. The frame is abandoned and no done pulse is issued.
- FSM states: IDLE, SRC_PORT_TX, DST_PORT_TX, LEN_TX, CSUM_TX. Each TX state lasts 2 cycles, indexed by a 1-bit counter, MSB byte first.
- Start handling: in IDLE, a start pulse at cycle N latches all inputs into holding registers. The inputs may change from cycle N+1 onward.
- Byte timing, with the start pulse at cycle N:
  - byte k (k=0..7) is on data_out with data_valid=1 in cycle N+1+k;
  - byte order: s_port[15:8], s_port[7:0], d_port[15:8], d_port[7:0], len[15:8], len[7:0], csum[15:8], csum[7:0];
  - udp_header_tx_done=1 in cycle N+8 only;
  - the FSM is back in IDLE in cycle N+9.
- Length field: udp_len + 16'd8, computed modulo 2^16. No overflow check; upstream guarantees udp_len <= 65507.
- Start while busy: a start pulse outside IDLE is ignored.
- Start at the return edge: a start pulse in cycle N+9 is accepted, giving back-to-back frames.
- Outside header bytes: data_out holds 8'h00 and data_valid=0.

Optional Feature:
- Macro UDP_CHECKSUM_EN.
- Defined: the checksum is the one's complement of the one's-complement 16-bit sum of ten terms:
  - ip_s_addr[31:16], ip_s_addr[15:0], ip_d_addr[31:16], ip_d_addr[15:0];
  - 16'h0011, length field, s_port, d_port, length field again;
  - payload_sum.
- Accumulation is 32-bit, two terms per cycle over cycles N+1..N+5. A two-pass carry fold is registered in N+6, so the checksum register is stable before byte 6 in cycle N+7.
- A computed value of 16'h0000 is transmitted as 16'hFFFF.
- Not defined: the checksum bytes are 8'h00, 8'h00; payload_sum is unused and no accumulator is synthesised.

Decomposition:
- Package udp_pkg holds:
  - the state enum type for IDLE..CSUM_TX;
  - UDP_PROTO = 8'h11;
  - UDP_HDR_LEN = 16'd8.
- Sub-module csum16_fold, used only under UDP_CHECKSUM_EN: a combinational 32->16 one's-complement fold (two carry passes) plus inversion. It can later be shared with the IP header checksum path.

Test Plan:
- Basic frame, macro off: s_port=0x1234, d_port=0x5678, udp_len=0, start pulse.
  - Expect bytes 12 34 56 78 00 08 00 00 in cycles N+1..N+8.
  - Expect done high only in N+8.
- Checksum, macro on: same ports, ip_s=0xC0A80001, ip_d=0xC0A80002, payload_sum=0.
  - Expect checksum bytes 15 DE.
- Zero checksum substitution: as above with payload_sum=0x000015DE.
  - The fold gives 0xFFFF and the computed checksum is 0x0000.
  - Expect transmitted checksum bytes FF FF.
- Length wrap and input latching: udp_len=16'hFFFC, with all inputs changed to zero at N+1.
  - Expect length bytes 00 04 and ports taken from the values latched at cycle N.
- Busy start and back-to-back:
  - a start pulse at N+3 is ignored, and the frame completes unchanged;
  - a start pulse at N+9 produces a second frame in cycles N+10..N+17.
- Reset mid-frame: areset=1 at cycle N+4.
  - Expect data_out=00, data_valid=0 from the next edge, and no done pulse.
  - A new start afterwards produces a correct frame.
